// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe_stage_reg inter-stage register.
//
// Contents:
//   pipe_state_t - occupancy state of the two-slot stage.
//                  EMPTY = no beats, FULL = main slot only, SKID = both slots.
//   STALL_CNT_W  - width of the optional stall counter
//                  (used only when PIPE_STAGE_PERF_EN is defined).
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } pipe_state_t;

    localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of the pipeline stage: a valid bit plus payload and
// control registers. Clear has priority over load for the valid bit; the
// payload registers only change on load and are not cleared by 'clear'.
//
// Ports:
//   clk, rst   - clock, asynchronous active-high reset (everything to 0)
//   load       - capture load_data/load_ctrl and set valid
//   clear      - drop the held beat (valid -> 0)
//   load_data  - payload to capture
//   load_ctrl  - control bits to capture
//   valid      - slot holds a beat
//   data, ctrl - held payload and control bits (unmasked)
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] load_data,
    input  logic [CTRL_W-1:0] load_ctrl,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
            ctrl <= '0;
        end else if (load) begin
            data <= load_data;
            ctrl <= load_ctrl;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, a one-entry
// skid buffer, synchronous flush and masking of control bits on bubbles.
//
// Parameters:
//   DATA_W - payload width, passed through unmasked
//   CTRL_W - side-effecting control bits, forced to 0 when out_valid = 0
//
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid/in_ready   - upstream handshake (in_ready is a flop output)
//   in_data, in_ctrl    - upstream payload and control bits
//   flush               - drop every held beat and the beat offered this cycle
//   out_valid/out_ready - downstream handshake (out_ready low = stall)
//   out_data, out_ctrl  - held payload and masked control bits
//   stall_cnt           - saturating count of out_valid & ~out_ready cycles,
//                         present only when PIPE_STAGE_PERF_EN is defined
//
// Build option: define PIPE_STAGE_PERF_EN to add the stall_cnt port/counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    pipe_state_t       state;

    logic              acc;
    logic              drn;

    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic [CTRL_W-1:0] m_ctrl;
    logic              m_load;
    logic              m_clear;
    logic              m_from_skid;
    logic [DATA_W-1:0] m_load_data;
    logic [CTRL_W-1:0] m_load_ctrl;

    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic [CTRL_W-1:0] s_ctrl;
    logic              s_load;
    logic              s_clear;

    assign acc = in_valid & in_ready;
    assign drn = m_valid & out_ready;

    // Slot control: what each slot does at the coming edge. Flush overrides
    // everything, so no load is raised while it is active.
    always_comb begin
        m_load      = 1'b0;
        m_clear     = flush;
        m_from_skid = 1'b0;
        s_load      = 1'b0;
        s_clear     = flush;
        if (!flush) begin
            case (state)
                EMPTY: begin
                    m_load = acc;
                end
                FULL: begin
                    if (acc && drn) begin
                        m_load = 1'b1;
                    end else if (acc) begin
                        s_load = 1'b1;
                    end else if (drn) begin
                        m_clear = 1'b1;
                    end
                end
                SKID: begin
                    // in_ready is low here, so only the drain can happen.
                    if (drn) begin
                        m_load      = 1'b1;
                        m_from_skid = 1'b1;
                        s_clear     = 1'b1;
                    end
                end
                default: begin
                    m_clear = 1'b1;
                    s_clear = 1'b1;
                end
            endcase
        end
    end

    assign m_load_data = m_from_skid ? s_data : in_data;
    assign m_load_ctrl = m_from_skid ? s_ctrl : in_ctrl;

    // Occupancy FSM. in_ready is registered alongside the state so it never
    // depends combinationally on out_ready; it is low exactly in SKID.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
        end else if (flush) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        state <= FULL;
                    end
                end
                FULL: begin
                    if (acc && !drn) begin
                        state    <= SKID;
                        in_ready <= 1'b0;
                    end else if (!acc && drn) begin
                        state <= EMPTY;
                    end
                end
                SKID: begin
                    if (drn) begin
                        state    <= FULL;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= EMPTY;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

    // Main slot feeds the output; skid slot catches the beat in flight when
    // the downstream stalls.
    pipe_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_main (
        .clk       (clk),
        .rst       (rst),
        .load      (m_load),
        .clear     (m_clear),
        .load_data (m_load_data),
        .load_ctrl (m_load_ctrl),
        .valid     (m_valid),
        .data      (m_data),
        .ctrl      (m_ctrl)
    );

    pipe_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (s_load),
        .clear     (s_clear),
        .load_data (in_data),
        .load_ctrl (in_ctrl),
        .valid     (s_valid),
        .data      (s_data),
        .ctrl      (s_ctrl)
    );

    // Output stage: control bits are masked on bubbles, payload is not.
    assign out_valid = m_valid;
    assign out_data  = m_data;
    assign out_ctrl  = m_valid ? m_ctrl : '0;

`ifdef PIPE_STAGE_PERF_EN
    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (&v) ? v : v + STALL_CNT_W'(1);
    endfunction

    // Counts stalled cycles; survives flush, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (m_valid && !out_ready) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [15:0] in_ctrl;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [15:0] out_ctrl;
`ifdef PIPE_STAGE_PERF_EN
    logic [15:0] stall_cnt;
`endif

    pipe_stage_reg #(
        .DATA_W (64),
        .CTRL_W (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the stage is a FIFO of capacity 2. A beat is taken when
    // fewer than 2 are held, the head leaves when out_ready is high, and flush
    // empties it (dropping the offered beat). Ctrl reads 0 when empty.
    typedef struct {
        logic [63:0] d;
        logic [15:0] c;
    } beat_t;

    beat_t       q[$];
    int unsigned m_stall;
    bit          room;
    beat_t       nb;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_stall = 0;
        end else begin
            room = (q.size() < 2);
            if (q.size() > 0 && !out_ready && m_stall < 32'hFFFF) m_stall = m_stall + 1;
            if (flush) begin
                q.delete();
            end else begin
                if (q.size() > 0 && out_ready) void'(q.pop_front());
                if (in_valid && room) begin
                    nb.d = in_data;
                    nb.c = in_ctrl;
                    q.push_back(nb);
                end
            end
        end
    end

    // Every-cycle comparison against the model, plus a log of beats the DUT
    // hands downstream (handshake completes at the following posedge).
    logic [63:0] dut_log[$];

    always @(negedge clk) begin
        chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
        chk("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
        chk("out_ctrl", {48'd0, out_ctrl}, (q.size() > 0) ? {48'd0, q[0].c} : 64'd0);
        if (q.size() > 0) chk("out_data", out_data, q[0].d);
`ifdef PIPE_STAGE_PERF_EN
        chk("stall_cnt", {48'd0, stall_cnt}, 64'(m_stall));
`endif
        if (out_valid && out_ready) dut_log.push_back(out_data);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int base;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_ctrl", {48'd0, out_ctrl}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_data", out_data, 64'd0);
        rst = 1'b0;
        tick();

        // Streaming 1..8 at full rate.
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 64'(i);
            in_ctrl  = 16'(i);
            tick();
            chk("stream_data", out_data, 64'(i));
            chk("stream_ready", {63'd0, in_ready}, 64'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_empty", {63'd0, out_valid}, 64'd0);

        // Stall and skid.
        base      = dut_log.size();
        in_valid  = 1'b1;
        in_data   = 64'd1;
        tick();
        in_data   = 64'd2;
        tick();
        in_data   = 64'd3;
        out_ready = 1'b0;
        tick();
        chk("skid_hold_data", out_data, 64'd2);
        chk("skid_in_ready", {63'd0, in_ready}, 64'd0);
        in_data = 64'd4;
        tick();
        tick();
        chk("skid_still_2", out_data, 64'd2);
        chk("skid_still_busy", {63'd0, in_ready}, 64'd0);
        out_ready = 1'b1;
        tick();
        chk("release_data3", out_data, 64'd3);
        chk("release_ready", {63'd0, in_ready}, 64'd1);
        tick();
        chk("release_data4", out_data, 64'd4);
        in_valid = 1'b0;
        tick();
        chk("skid_count", 64'(dut_log.size() - base), 64'd4);
        for (int k = 0; k < 4; k++) begin
            if (base + k < dut_log.size()) chk("skid_order", dut_log[base + k], 64'(k + 1));
        end

        // Flush in SKID (M=5, S=6) with 7 offered.
        base      = dut_log.size();
        in_valid  = 1'b1;
        in_data   = 64'd5;
        in_ctrl   = 16'h00F0;
        out_ready = 1'b0;
        tick();
        in_data = 64'd6;
        tick();
        chk("pre_flush_skid", {63'd0, in_ready}, 64'd0);
        in_data = 64'd7;
        flush   = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_out_ctrl", {48'd0, out_ctrl}, 64'd0);
        chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b1;
        tick();
        tick();
        chk("flush_nothing_out", 64'(dut_log.size() - base), 64'd0);

        // Flush while in_ready=1 drops the offered beat; flush with drain
        // still delivers the head beat.
        in_valid = 1'b1;
        in_data  = 64'd10;
        tick();
        in_data = 64'd9;
        flush   = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_drn_empty", {63'd0, out_valid}, 64'd0);
        tick();
        chk("flush_drn_count", 64'(dut_log.size() - base), 64'd1);
        if (dut_log.size() > base) chk("flush_drn_beat", dut_log[base], 64'd10);

        // Bubble masking.
        in_valid = 1'b1;
        in_data  = 64'd20;
        in_ctrl  = 16'hFFFF;
        tick();
        chk("mask_ctrl_live", {48'd0, out_ctrl}, 64'hFFFF);
        in_valid = 1'b0;
        tick();
        chk("mask_ctrl_bubble", {48'd0, out_ctrl}, 64'd0);
        tick();

        // Asynchronous reset while in SKID.
        in_valid  = 1'b1;
        in_data   = 64'd40;
        out_ready = 1'b0;
        tick();
        in_data = 64'd41;
        tick();
        in_valid = 1'b0;
        chk("pre_rst_skid", {63'd0, in_ready}, 64'd0);
        rst = 1'b1;
        #1;
        chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("post_rst_ready", {63'd0, in_ready}, 64'd1);
`ifdef PIPE_STAGE_PERF_EN
        chk("post_rst_stall", {48'd0, stall_cnt}, 64'd0);
`endif
        in_valid = 1'b1;
        in_data  = 64'd50;
        tick();
        in_valid = 1'b0;
        chk("post_rst_accept", out_data, 64'd50);
        tick();

`ifdef PIPE_STAGE_PERF_EN
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b1;
        in_data  = 64'd30;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (10) tick();
        chk("perf_10", {48'd0, stall_cnt}, 64'd10);
        repeat (65540) tick();
        chk("perf_sat", {48'd0, stall_cnt}, 64'hFFFF);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("perf_keep_on_flush", {48'd0, stall_cnt}, 64'hFFFF);
        out_ready = 1'b1;
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register with a valid/ready handshake, a one-entry skid buffer, synchronous flush and bubble masking of control bits. It sits between any two pipeline stages, for example decode→execute, and replaces hand-built per-signal enable/reset flop banks. Stall becomes back-pressure (`out_ready` low), and branch flush becomes a `flush` pulse. Control bits are forced to zero whenever the output is not valid, so downstream stages never see a spurious write, memory enable, jump or halt.

## Interface
Parameters:
- `DATA_W`, 64: payload width (PC, instruction, operands). Passed through unmasked.
- `CTRL_W`, 16: side-effecting control bits. Zeroed when the output is not valid.

Ports:
- `clk` in 1: clock. The block uses this one clock only.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: upstream holds a valid beat.
- `in_ready` out 1: the block accepts a beat this cycle. Registered.
- `in_data` in DATA_W: upstream payload.
- `in_ctrl` in CTRL_W: upstream control bits.
- `flush` in 1: discard all held beats and any beat offered this cycle.
- `out_valid` out 1: output beat valid.
- `out_ready` in 1: downstream accepts the beat. Low means stall.
- `out_data` out DATA_W: held payload.
- `out_ctrl` out CTRL_W: held control bits, equal to 0 when `out_valid`=0.
- `stall_cnt` out 16: present only with `PIPE_STAGE_PERF_EN`.

## Operation
- **Storage:** a main slot (M) and a skid slot (S), each with its own valid bit.
- **State machine:**
  - EMPTY: M invalid, S invalid.
  - FULL: M valid, S invalid.
  - SKID: M valid, S valid.
- **Handshake events:**
  - acc = `in_valid & in_ready`
  - drn = `out_valid & out_ready`
- **EMPTY:**
  - acc → load M, go to FULL.
- **FULL:**
  - acc & drn → load M, stay FULL.
  - acc & ~drn → load S, go to SKID.
  - ~acc & drn → go to EMPTY.
- **SKID:**
  - drn → copy S to M, go to FULL.
  - No accept is possible, because `in_ready`=0.
- **`in_ready`:** `in_ready` = ~S.valid.
  - Registered, with no combinational path from `out_ready`.
  - Deasserts the cycle after entering SKID.
- **Flush:**
  - `flush`=1 wins over every other event.
  - Next state is EMPTY and both valid bits clear.
  - The beat offered that cycle is dropped, even if `in_ready`=1.
  - Upstream must treat it as consumed.
  - Data flops are not required to clear.
- **Outputs:**
  - `out_valid` = M.valid.
  - `out_data` = M.data.
  - `out_ctrl` = M.valid ? M.ctrl : 0.
- **Order:** beats leave in arrival order. None are lost or duplicated except by flush.

## Timing
- **Reset values:** while `rst` is high, state is EMPTY, `out_valid`=0 and `out_ctrl`=0. `in_ready`=1, and `stall_cnt`=0 when present. `out_data` is 0.
- **Latency:** a beat accepted at edge N is visible on `out_*` after edge N, one cycle.
- **Throughput:** one beat per cycle in steady state.
- **Stall entry:** `out_ready` drops while a beat streams in. The in-flight beat lands in S, and `in_ready` is low from the next cycle.
- **Stall release:** when `out_ready` returns, S moves to M at that edge. `in_ready` is 1 one cycle later.
- **Same-cycle flush and drn:** the downstream handshake completes, and the block is EMPTY afterwards.
- **Reset asserted mid-operation:** both slots are discarded immediately, asynchronously.
- **Reset release:** the block is ready in the first cycle after release.

## Configuration
- **`PIPE_STAGE_PERF_EN` defined:**
  - `stall_cnt` counts cycles with `out_valid & ~out_ready`.
  - It saturates at 16'hFFFF.
  - It clears on `rst` only, not on flush.
- **Not defined:** the port and the counter are absent, with zero added logic.

## Structure
- **Package `pipe_pkg`:**
  - state enum `pipe_state_t` with values EMPTY, FULL and SKID.
  - localparam for the `stall_cnt` width (16).
- **Sub-module `pipe_slot`:**
  - one valid+data+ctrl register with load enable and clear.
  - instantiated twice, for M and S.
- **Top level:** the FSM, the muxes into M and the output masking live in `pipe_stage_reg`.

## Test plan
- **Streaming:** `out_ready`=1, `in_valid`=1 for 8 cycles with data 1..8 → `out_data` 1..8 on consecutive cycles starting one cycle later, `in_ready` stays 1.
- **Stall and skid:**
  - Stimulus: stream with data 1..N and `out_ready`=1; 2 enters at edge N, 3 at edge N+1; `out_ready`=0 from cycle N+1 for 3 cycles.
  - Required response: S holds 3, `in_ready`=0 from cycle N+2, `out_data` holds 2.
  - On release, order is 2, 3, 4 with no loss.
- **Flush:**
  - Stimulus: in SKID (M=5, S=6) pulse `flush` with `in_valid`=1, data 7.
  - Required response: next cycle `out_valid`=0, `out_ctrl`=0, `in_ready`=1, and 7 is never emitted.
- **Bubble masking:** `in_ctrl`=16'hFFFF, then `in_valid`=0 and drain → `out_ctrl`=0 every cycle `out_valid`=0.
- **Async reset:**
  - Stimulus: assert `rst` between clock edges while in SKID.
  - Required response: `out_valid` falls immediately; after release `in_ready`=1, state is EMPTY, and `stall_cnt`=0 with `PIPE_STAGE_PERF_EN`.
- **Perf counter (`PIPE_STAGE_PERF_EN`):**
  - Hold `out_valid`=1, `out_ready`=0 for 10 cycles → `stall_cnt`=10.
  - Preload near 16'hFFFF with a long stall → value sticks at 16'hFFFF.
